md_sched: RTL

- Multiply/divide scheduler for the 5-stage pipeline.
- Accepts mult/multu/div/divu/mthi/mtlo/mfhi/mflo decoded in E stage.
- Owns the HI/LO registers and a fixed-latency busy counter.
- Raises a stall to the hazard logic when a D-stage mult/div-class instruction would collide with an in-flight operation.

---
 rtl/md_sched_pkg.sv | 36 +++
 rtl/md_sched_arith.sv | 55 +++++
 rtl/md_sched.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/md_sched_pkg.sv
// Shared definitions for the multiply/divide scheduler.
// Provides the E-stage md opcode encoding, the scheduler state encoding,
// the busy-counter width and a helper that classifies mult/div opcodes.
package md_defs;

  localparam int unsigned MD_OP_W  = 4;
  localparam int unsigned MD_CNT_W = 8;

  typedef enum logic [MD_OP_W-1:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MFHI  = 4'd5,
    MD_MFLO  = 4'd6,
    MD_MTHI  = 4'd7,
    MD_MTLO  = 4'd8
  } md_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } md_state_e;

  // True for opcodes that occupy the multi-cycle unit
  function automatic logic is_muldiv(input logic [MD_OP_W-1:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  // True for divide opcodes
  function automatic logic is_div(input logic [MD_OP_W-1:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_sched_arith.sv
// md_arith: purely combinational mult/div datapath.
// Ports: op (md opcode), a/b (operands) -> hi_res/lo_res (64-bit result split),
//        div0 (divide opcode with zero divisor; results then meaningless).
module md_arith
  import md_defs::*;
(
  input  logic [MD_OP_W-1:0] op,
  input  logic [31:0]        a,
  input  logic [31:0]        b,
  output logic [31:0]        hi_res,
  output logic [31:0]        lo_res,
  output logic               div0
);

  logic [63:0] prod;
  logic [31:0] ua, ub, dsor, quo, rem;
  logic        neg_q, neg_r;

  // Signed divide runs on magnitudes so INT_MIN / -1 wraps cleanly to INT_MIN
  always_comb begin
    ua    = a;
    ub    = b;
    neg_q = 1'b0;
    neg_r = 1'b0;
    if (op == MD_DIV) begin
      ua    = a[31] ? 32'(-a) : a;
      ub    = b[31] ? 32'(-b) : b;
      neg_q = a[31] ^ b[31];
      neg_r = a[31];
    end
    dsor = (ub == 32'd0) ? 32'd1 : ub;
    quo  = ua / dsor;
    rem  = ua % dsor;
  end

  always_comb begin
    hi_res = '0;
    lo_res = '0;
    div0   = 1'b0;
    prod   = '0;
    case (op)
      MD_MULT:  prod = {{32{a[31]}}, a} * {{32{b[31]}}, b};
      MD_MULTU: prod = {32'd0, a} * {32'd0, b};
      default:  prod = '0;
    endcase
    if (is_div(op)) begin
      lo_res = neg_q ? 32'(-quo) : quo;
      hi_res = neg_r ? 32'(-rem) : rem;
      div0   = (b == 32'd0);
    end else begin
      {hi_res, lo_res} = prod;
    end
  end

endmodule

// File: rtl/md_sched.sv
// md_sched: multiply/divide scheduler for the 5-stage pipeline.
// Owns HI/LO, latches the md_arith result at start and commits it after a
// fixed busy period; stalls D-stage md instructions while the unit is busy.
// Ports: clk, reset (async active-low), e_valid/op_e/a_e/b_e (E-stage op),
//        d_is_md (D-stage md op), start/md_stall/md_rdata (combinational),
//        busy/hi/lo (registered).
// Build option: MD_DIV0_FAST_EN makes divide-by-zero occupy a single cycle.
module md_sched
  import md_defs::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               e_valid,
  input  logic [MD_OP_W-1:0] op_e,
  input  logic [31:0]        a_e,
  input  logic [31:0]        b_e,
  input  logic               d_is_md,
  output logic               start,
  output logic               busy,
  output logic               md_stall,
  output logic [31:0]        md_rdata,
  output logic [31:0]        hi,
  output logic [31:0]        lo
);

  md_state_e           state_q, state_d;
  logic                busy_q, busy_d;
  logic [MD_CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]         hi_q, hi_d, lo_q, lo_d;
  logic [31:0]         pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic                pend_div0_q, pend_div0_d;

  logic [31:0]         hi_res, lo_res;
  logic                div0;
  logic [MD_CNT_W-1:0] load_cnt;

  md_arith u_arith (
    .op     (op_e),
    .a      (a_e),
    .b      (b_e),
    .hi_res (hi_res),
    .lo_res (lo_res),
    .div0   (div0)
  );

  assign start    = e_valid & is_muldiv(op_e) & ~busy_q;
  assign md_stall = d_is_md & (busy_q | start);
  assign busy     = busy_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

  // Read port for mfhi/mflo in E
  always_comb begin
    md_rdata = '0;
    if (op_e == MD_MFHI)      md_rdata = hi_q;
    else if (op_e == MD_MFLO) md_rdata = lo_q;
  end

  // Busy period for the op being started
  always_comb begin
    load_cnt = MD_CNT_W'(MULT_CYCLES);
    if (is_div(op_e)) begin
`ifdef MD_DIV0_FAST_EN
      load_cnt = div0 ? MD_CNT_W'(1) : MD_CNT_W'(DIV_CYCLES);
`else
      load_cnt = MD_CNT_W'(DIV_CYCLES);
`endif
    end
  end

  // Next-state and datapath updates
  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    cnt_d       = cnt_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    pend_hi_d   = pend_hi_q;
    pend_lo_d   = pend_lo_q;
    pend_div0_d = pend_div0_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = BUSY;
          busy_d      = 1'b1;
          cnt_d       = load_cnt;
          pend_hi_d   = hi_res;
          pend_lo_d   = lo_res;
          pend_div0_d = div0;
        end else if (e_valid && (op_e == MD_MTHI)) begin
          hi_d = a_e;
        end else if (e_valid && (op_e == MD_MTLO)) begin
          lo_d = a_e;
        end
      end
      BUSY: begin
        if (cnt_q == MD_CNT_W'(1)) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          cnt_d   = '0;
          // Divide by zero leaves HI/LO untouched
          if (!pend_div0_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
        end else begin
          cnt_d = cnt_q - MD_CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      cnt_q       <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      pend_hi_q   <= '0;
      pend_lo_q   <= '0;
      pend_div0_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      cnt_q       <= cnt_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      pend_hi_q   <= pend_hi_d;
      pend_lo_q   <= pend_lo_d;
      pend_div0_q <= pend_div0_d;
    end
  end

  // Hazard logic must keep md ops and HI/LO writes out of E while busy
  a_no_md_op_while_busy: assert property (
    @(posedge clk) disable iff (!reset)
      !(e_valid && busy_q && (is_muldiv(op_e) || (op_e == MD_MTHI) || (op_e == MD_MTLO))))
    else $error("md_sched: md op or HI/LO write issued while busy");

endmodule
